avg_divide: RTL and testbench

AVG_DIVIDE -- requirements
Module: avg_divide

---
 rtl/avg_divide.sv | 185 ++++++++++++++++++
 tb/tb_avg_divide.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/avg_divide.sv
// avg_divide: frame averager back end. A frame counter snoops the
// data_first/data_last strobes; when the upstream sum stage reports a frame
// sum, a restoring divider produces floor(sum/count) and sum mod count.
//
// Handshake: sum_valid is a one-cycle pulse with no back-pressure. It is
// accepted only in IDLE (busy=0). A pulse seen while busy=1 is dropped and
// flagged on ovr in the same cycle. out_valid is a one-cycle pulse, and
// avg_out/rem_out hold their value until the next pulse.
module avg_divide #(
    parameter int NOF_BITS = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_first,
    input  logic                data_last,
    input  logic                sum_valid,
    input  logic [NOF_BITS:0]   sum_in,
    output logic [NOF_BITS-1:0] avg_out,
    output logic [CNT_BITS-1:0] rem_out,
    output logic                out_valid,
    output logic                busy,
    output logic                ovr
);

    localparam int SW = NOF_BITS + 1;        // dividend / raw quotient width
    localparam int BW = $clog2(SW + 1);      // iteration counter width

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    // Frame counter state
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] div_cnt_q, div_cnt_d;
    logic                counting_q, counting_d;
    logic [CNT_BITS-1:0] cnt_inc;

    // Divider state
    state_t              state_q, state_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]       quo_q, quo_d;
    logic [CNT_BITS-1:0] rem_q, rem_d;
    logic [CNT_BITS-1:0] divisor_q, divisor_d;
    logic                div_zero_q, div_zero_d;
    logic [NOF_BITS-1:0] avg_q, avg_d;
    logic [CNT_BITS-1:0] rem_out_q, rem_out_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    // One restoring-division step
    logic [CNT_BITS:0]   trial;
    logic [CNT_BITS:0]   diff;
    logic                ge;
    logic [CNT_BITS-1:0] rem_step;
    logic [SW-1:0]       quo_step;

    // Frame counter: saturating count, latched into div_cnt on data_last
    always_comb begin
        cnt_inc    = (cnt_q == {CNT_BITS{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        cnt_d      = cnt_q;
        div_cnt_d  = div_cnt_q;
        counting_d = counting_q;
        if (counting_q) begin
            // data_first mid-frame is just another sample
            cnt_d = cnt_inc;
            if (data_last) begin
                div_cnt_d  = cnt_inc;
                counting_d = 1'b0;
            end
        end else if (data_first) begin
            cnt_d = CNT_BITS'(1);
            if (data_last) begin
                div_cnt_d = CNT_BITS'(1);
            end else begin
                counting_d = 1'b1;
            end
        end
    end

    // Frame counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_cnt_q  <= '0;
            counting_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cnt_q  <= div_cnt_d;
            counting_q <= counting_d;
        end
    end

    // Divider step: shift next dividend bit into the partial remainder
    always_comb begin
        trial    = {rem_q, quo_q[SW-1]};
        diff     = trial - {1'b0, divisor_q};
        ge       = (trial >= {1'b0, divisor_q});
        rem_step = ge ? diff[CNT_BITS-1:0] : trial[CNT_BITS-1:0];
        quo_step = {quo_q[SW-2:0], ge};
    end

    // Divider FSM next state; results are loaded on the last DIV step so
    // out_valid is high while the FSM sits in DONE
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        div_zero_d  = div_zero_q;
        avg_d       = avg_q;
        rem_out_d   = rem_out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (sum_valid) begin
                    quo_d      = sum_in;
                    rem_d      = '0;
                    divisor_d  = div_cnt_q;
                    div_zero_d = (div_cnt_q == '0);
                    bit_cnt_d  = BW'(NOF_BITS);
                    busy_d     = 1'b1;
                    state_d    = S_DIV;
                end
            end
            S_DIV: begin
                quo_d     = quo_step;
                rem_d     = rem_step;
                bit_cnt_d = bit_cnt_q - 1'b1;
                if (bit_cnt_q == '0) begin
                    // Quotient top bit is dropped: sum <= count*max sample
                    avg_d       = div_zero_q ? '0 : quo_step[NOF_BITS-1:0];
                    rem_out_d   = div_zero_q ? '0 : rem_step;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Divider FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            div_zero_q  <= 1'b0;
            avg_q       <= '0;
            rem_out_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            div_zero_q  <= div_zero_d;
            avg_q       <= avg_d;
            rem_out_q   <= rem_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign avg_out   = avg_q;
    assign rem_out   = rem_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // Overrun must flag in the cycle of the rejected pulse, so it is decoded
    // from the registered busy flag rather than registered itself
    assign ovr       = sum_valid & busy_q;

endmodule

// File: tb/tb_avg_divide.sv
// tb_avg_divide: directed bench for avg_divide. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_avg_divide;

  localparam int NB  = 32;
  localparam int CB  = 16;
  localparam int LAT = NB + 2;

  logic          clk;
  logic          rst_n;
  logic          data_first;
  logic          data_last;
  logic          sum_valid;
  logic [NB:0]   sum_in;
  logic [NB-1:0] avg_out;
  logic [CB-1:0] rem_out;
  logic          out_valid;
  logic          busy;
  logic          ovr;

  int n_cmp = 0;
  int n_err = 0;
  logic [NB+CB-1:0] exp_q[$];

  avg_divide #(.NOF_BITS(NB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .data_first(data_first), .data_last(data_last),
    .sum_valid(sum_valid), .sum_in(sum_in), .avg_out(avg_out),
    .rem_out(rem_out), .out_valid(out_valid), .busy(busy), .ovr(ovr)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one frame of n samples; data_first is repeated at sample refirst_at
  task automatic drive_frame(input int n, input int refirst_at);
    for (int i = 0; i < n; i++) begin
      data_first = (i == 0) || (i == refirst_at);
      data_last  = (i == n - 1);
      @(negedge clk);
    end
    data_first = 1'b0;
    data_last  = 1'b0;
  endtask

  // raise sum_valid and push the model result
  task automatic push_sum(input logic [NB:0] sum, input int cnt);
    logic [NB:0]   q;
    logic [NB:0]   r;
    if (cnt == 0) begin
      q = '0;
      r = '0;
    end else begin
      q = sum / (NB+1)'(cnt);
      r = sum % (NB+1)'(cnt);
    end
    exp_q.push_back({q[NB-1:0], r[CB-1:0]});
    sum_in    = sum;
    sum_valid = 1'b1;
  endtask

  // wait for out_valid; optionally re-pulse sum_valid at cycle ovr_at
  task automatic wait_result(input string tag, input int ovr_at);
    int n = 0;
    int ovr_seen = 0;
    bit got = 0;
    logic [NB+CB-1:0] e;
    #1;
    if (ovr) ovr_seen++;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        got = 1;
      end else begin
        sum_valid = (n == ovr_at);
        sum_in    = sum_in ^ 33'h1_2345_6789;
        #1;
        if (ovr) ovr_seen++;
        if (n == 2) check({tag, "_busy"}, 64'(busy), 64'd1);
      end
    end
    sum_valid = 1'b0;
    check({tag, "_seen"}, 64'(got), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    check({tag, "_ovr"}, 64'(ovr_seen), (ovr_at != 0) ? 64'd1 : 64'd0);
    check({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_avg"}, 64'(avg_out), 64'(e[NB+CB-1:CB]));
      check({tag, "_rem"}, 64'(rem_out), 64'(e[CB-1:0]));
    end
  endtask

  // result must hold and the block must return to idle
  task automatic hold_check(input string tag);
    logic [NB-1:0] a;
    logic [CB-1:0] r;
    a = avg_out;
    r = rem_out;
    @(negedge clk);
    check({tag, "_pulse"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_hold_avg"}, 64'(avg_out), 64'(a));
    check({tag, "_hold_rem"}, 64'(rem_out), 64'(r));
  endtask

  initial begin
    int pulses;
    rst_n      = 1'b0;
    data_first = 1'b0;
    data_last  = 1'b0;
    sum_valid  = 1'b0;
    sum_in     = '0;
    repeat (3) @(negedge clk);
    check("rst_avg", 64'(avg_out), 64'd0);
    check("rst_rem", 64'(rem_out), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovr", 64'(ovr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // divisor 0: no frame since reset
    push_sum(33'd55, 0);
    wait_result("div0", 0);
    hold_check("div0");

    // 4-sample frame 10,20,30,40
    drive_frame(4, -1);
    push_sum(33'd100, 4);
    wait_result("four", 0);
    hold_check("four");

    // 1-sample frame, first and last together
    drive_frame(1, -1);
    push_sum(33'd7, 1);
    wait_result("one", 0);
    hold_check("one");

    // remainder frame 1,1,2 then a back-to-back sum with the same count
    drive_frame(3, -1);
    push_sum(33'd4, 3);
    wait_result("rem", 0);
    @(negedge clk);
    push_sum(33'd10, 3);
    wait_result("b2b", 0);
    hold_check("b2b");

    // data_first repeated mid-frame, then a stray data_last while idle
    drive_frame(5, 2);
    data_last = 1'b1;
    @(negedge clk);
    data_last = 1'b0;
    push_sum(33'd23, 5);
    wait_result("refirst", 0);
    hold_check("refirst");

    // maximum-value frame
    drive_frame(2, -1);
    push_sum(33'h1_FFFF_FFFE, 2);
    wait_result("max", 0);
    hold_check("max");

    // overrun 5 cycles after the accepted sum
    drive_frame(3, -1);
    push_sum(33'd301, 3);
    wait_result("ovr", 5);
    hold_check("ovr");

    // reset during DIV
    drive_frame(4, -1);
    sum_in    = 33'd100;
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_avg", 64'(avg_out), 64'd0);
    check("mid_rst_rem", 64'(rem_out), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("mid_rst_nopulse", 64'(pulses), 64'd0);
    check("mid_rst_avg_late", 64'(avg_out), 64'd0);
    drive_frame(2, -1);
    push_sum(33'd6, 2);
    wait_result("post_rst", 0);
    hold_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
